wide_add_seq: RTL
=================

Name: wide_add_seq

Overview:
Multi-precision add/subtract sequencer built around one add_32_bit instance. It accepts a packet of 32-bit operand word pairs, least-significant word first, one word per cycle. It chains the carry between words in a register and streams registered sum words downstream. On the last word it reports carry-out and signed overflow. It sits directly upstream of add_32_bit, driving its a/b/c_in, and directly consumes its s/g_out/p_out.

Parameters:
MAX_WORDS, 8, maximum words per packet; words beyond this are flagged as an error.
IDXW, 3, width of the word-index output; must satisfy 2^IDXW >= MAX_WORDS.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand word pair valid
in_ready  output  1  block can accept a word this cycle
in_a  input  32  operand A word
in_b  input  32  operand B word
in_last  input  1  marks the final (most-significant) word of the packet
in_sub  input  1  1 = A-B, 0 = A+B; sampled on the first word only
in_cin  input  1  initial carry for an add packet; sampled on the first word only
out_valid  output  1  result word valid
out_ready  input  1  downstream accepts the result word
out_sum  output  32  sum/difference word
out_idx  output  IDXW  word index within the packet, 0 = LSW
out_last  output  1  final word of the packet
out_cout  output  1  carry-out of the final word; 0 when out_last=0
out_ovf  output  1  signed overflow of the whole packet; 0 when out_last=0
out_err  output  1  sticky per packet: packet longer than MAX_WORDS

Behaviour:
- All state is cleared by rst_n=0 sampled at a clk edge. Reset values: out_valid=0, out_sum=0, out_idx=0, out_last=0, out_cout=0, out_ovf=0, out_err=0, FSM=IDLE, carry reg=0, word counter=0.
- A handshake fires on an edge where in_valid and in_ready are both 1. Likewise, the output handshake fires when out_valid and out_ready are both 1.
- in_ready = !out_valid | out_ready. This is a single output register stage, so full throughput is one word per cycle with no bubbles.
- Latency: an accepted word appears on out_* on the next cycle. The output register holds its value while out_valid=1 and out_ready=0.
- Adder drive: a=in_a; b = in_sub_eff ? ~in_b : in_b.
- c_in depends on FSM state:
  - IDLE: c_in = in_sub ? 1 : in_cin.
  - BUSY: c_in = carry reg.
- in_sub_eff is in_sub in IDLE and the latched sub flag in BUSY.
- Word carry-out: c32 = g_out | (p_out & c_in). g_out/p_out are the group generate/propagate over all 32 bits.
- Bit-31 carry-in: c31 = s[31] ^ a[31] ^ b[31], using the driven b. Signed overflow = c31 ^ c32, reported only on the last word.
- FSM states:
  - IDLE: waiting for the first word. On a handshake with in_last=0, latch in_sub, store c32, set counter=1, and go to BUSY. On a handshake with in_last=1, this is a single-word packet: emit with out_last=1 and stay in IDLE.
  - BUSY: on each handshake, update the carry reg and increment the counter. When in_last=1, return to IDLE and clear the carry reg and counter.
- out_idx = counter value at acceptance. The counter saturates at MAX_WORDS-1 for indexing.
- If a word is accepted while counter = MAX_WORDS, set the err flag. The err flag is reflected on out_err of that word and of all subsequent words through the last word, then cleared. Arithmetic continues normally when err is set.
- in_sub and in_cin are ignored on non-first words.
- Subtraction cout semantics: cout=1 means no borrow.
- Reset mid-packet: the partial packet is discarded, no out_last is emitted, and the next accepted word is treated as a first word.
- Nothing is accepted while in_valid=0. Gaps mid-packet are allowed, and the carry reg holds across them.

Test Plan:
- 2-word add: A=0x00000000_FFFFFFFF, B=0x00000000_00000001, cin=0 -> idx0 sum=0x00000000; idx1 sum=0x00000001, last=1, cout=0, ovf=0.
- 2-word add with wrap: A=B=0xFFFFFFFF_FFFFFFFF, cin=0 -> sums 0xFFFFFFFE, 0xFFFFFFFF; cout=1, ovf=0.
- Single-word signed overflow: A=0x7FFFFFFF, B=0x00000001 -> sum=0x80000000, last=1, cout=0, ovf=1. Also cin=1 with A=B=0 -> sum=1.
- 2-word subtract: A=0x00000001_00000000, B=1, sub=1 -> sums 0xFFFFFFFF, 0x00000000; cout=1 (no borrow), ovf=0. Reversed operands -> sums 0x00000001, 0xFFFFFFFF; cout=0.
- Backpressure: stream 4 words with out_ready low for 3 cycles mid-packet -> in_ready=0 during the stall, no word lost or duplicated, idx 0..3 in order, and sums match a 128-bit reference model.
- Reset mid-packet and overlength: assert rst_n=0 after word 1 -> all outputs return to reset values, and the next 1-word packet has idx=0 and uses its own cin. Send a 9-word packet with MAX_WORDS=8 -> out_err=1 on word 9 only, sum still correct.

Source files
------------

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract sequencer: streams 32-bit word pairs LSW first
// through one add_32_bit and chains the carry between words of a packet.

module add_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        g_out,
  output logic        p_out
);

  logic [32:0] raw;

  // Group generate is the carry of a+b with no carry-in; propagate means a^b is all ones.
  assign raw   = {1'b0, a} + {1'b0, b};
  assign g_out = raw[32];
  assign p_out = &(a ^ b);
  assign s     = a + b + {31'b0, c_in};

endmodule

module wide_add_seq #(
  parameter int MAX_WORDS = 8,
  parameter int IDXW      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic            in_last,
  input  logic            in_sub,
  input  logic            in_cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_sum,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            out_cout,
  output logic            out_ovf,
  output logic            out_err
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic            sub_lat, sub_nxt;
  logic            carry, carry_nxt;
  logic            err, err_nxt;
  logic [CW-1:0]   count, count_nxt;

  logic            fire;
  logic            sub_eff;
  logic            c_in;
  logic [31:0]     b_drv;
  logic [31:0]     s;
  logic            g_out;
  logic            p_out;
  logic            c32;
  logic            c31;
  logic            ovf;
  logic            word_err;
  logic [IDXW-1:0] idx;

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;

  // The first word of a packet takes mode and carry-in straight from the inputs.
  assign sub_eff = (state == IDLE) ? in_sub : sub_lat;
  assign b_drv   = sub_eff ? ~in_b : in_b;
  assign c_in    = (state == IDLE) ? (in_sub ? 1'b1 : in_cin) : carry;

  add_32_bit u_add (
    .a     (in_a),
    .b     (b_drv),
    .c_in  (c_in),
    .s     (s),
    .g_out (g_out),
    .p_out (p_out)
  );

  assign c32 = g_out | (p_out & c_in);
  assign c31 = s[31] ^ in_a[31] ^ b_drv[31];
  assign ovf = c31 ^ c32;

  assign word_err = err || (count == CW'(MAX_WORDS));
  assign idx      = (count >= CW'(MAX_WORDS - 1)) ? IDXW'(MAX_WORDS - 1) : IDXW'(count);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sub_lat <= 1'b0;
      carry   <= 1'b0;
      err     <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      sub_lat <= sub_nxt;
      carry   <= carry_nxt;
      err     <= err_nxt;
      count   <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sub_nxt   = sub_lat;
    carry_nxt = carry;
    err_nxt   = err;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (fire && !in_last) begin
          sub_nxt   = in_sub;
          carry_nxt = c32;
          count_nxt = CW'(1);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (fire) begin
          if (in_last) begin
            state_nxt = IDLE;
            carry_nxt = 1'b0;
            count_nxt = '0;
            err_nxt   = 1'b0;
          end else begin
            carry_nxt = c32;
            err_nxt   = word_err;
            // Stop at MAX_WORDS so every further word keeps flagging the overrun.
            if (count != CW'(MAX_WORDS)) begin
              count_nxt = count + CW'(1);
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_sum   <= s;
      out_idx   <= idx;
      out_last  <= in_last;
      out_cout  <= in_last & c32;
      out_ovf   <= in_last & ovf;
      out_err   <= word_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
